// File: rtl/jtag_host.sv
// JTAG initiator: walks a target TAP from Run-Test/Idle through one IR or DR
// scan of up to 64 bits, or a TMS=1 reset sequence, and returns captured TDO.
//
// state      | meaning
// RESET_SEQ  | RESET_TCKS TCKs with TMS=1, then one TCK with TMS=0
// IDLE       | TCK parked low, waiting for start_i / tap_reset_i
// HEADER     | RTI -> Shift-DR (TMS 1,0,0) or Shift-IR (TMS 1,1,0,0)
// SHIFT      | len TCKs, TDI from latched data, TDO captured, TMS=1 on last
// TRAILER    | Exit1 -> Update -> RTI (TMS 1,0)
// DONE       | one-clk done_o pulse, data_o refreshed after a scan
module jtag_host #(
    parameter int CLK_DIV    = 4,
    parameter int RESET_TCKS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        is_ir_i,
    input  logic [6:0]  len_i,
    input  logic [63:0] data_i,
    input  logic        tap_reset_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] data_o,
    output logic        jtag_clk,
    output logic        jtag_tms,
    output logic        jtag_tdi,
    input  logic        jtag_tdo
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_RESET_SEQ,
        ST_IDLE,
        ST_HEADER,
        ST_SHIFT,
        ST_TRAILER,
        ST_DONE
    } state_t;

    state_t            state;
    logic              lead;
    logic [DIV_W-1:0]  div_cnt;
    logic [7:0]        tck_idx;
    logic [6:0]        shift_len;
    logic              ir_q;
    logic [63:0]       shift_data;
    logic [63:0]       capture;
    logic              reset_pend;

    state_t            adv_state;
    logic [7:0]        adv_idx;
    logic              adv_tdi;

    // TMS level for TCK number i of the given state
    function automatic logic tms_of(input state_t s, input logic [7:0] i,
                                    input logic ir, input logic [6:0] len);
        logic t;
        t = 1'b0;
        case (s)
            ST_RESET_SEQ: t = (i < 8'(RESET_TCKS));
            ST_HEADER:    t = (i == 8'd0) || (ir && (i == 8'd1));
            ST_SHIFT:     t = (i == ({1'b0, len} - 8'd1));
            ST_TRAILER:   t = (i == 8'd0);
            default:      t = 1'b0;
        endcase
        return t;
    endfunction

    // Which TCK follows the current one
    always_comb begin
        adv_state = state;
        adv_idx   = tck_idx + 8'd1;
        case (state)
            ST_RESET_SEQ: begin
                if (tck_idx == 8'(RESET_TCKS)) adv_state = ST_DONE;
            end
            ST_HEADER: begin
                if (tck_idx == (ir_q ? 8'd3 : 8'd2)) begin
                    adv_state = ST_SHIFT;
                    adv_idx   = 8'd0;
                end
            end
            ST_SHIFT: begin
                if (tck_idx == ({1'b0, shift_len} - 8'd1)) begin
                    adv_state = ST_TRAILER;
                    adv_idx   = 8'd0;
                end
            end
            ST_TRAILER: begin
                if (tck_idx == 8'd1) adv_state = ST_DONE;
            end
            default: ;
        endcase
    end

    always_comb begin
        adv_tdi = 1'b0;
        if (adv_state == ST_SHIFT)
            adv_tdi = (state == ST_SHIFT) ? shift_data[1] : shift_data[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RESET_SEQ;
            lead       <= 1'b1;
            div_cnt    <= '0;
            tck_idx    <= '0;
            shift_len  <= '0;
            ir_q       <= 1'b0;
            shift_data <= '0;
            capture    <= '0;
            reset_pend <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            data_o     <= '0;
            jtag_clk   <= 1'b0;
            jtag_tms   <= 1'b1;
            jtag_tdi   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state != ST_IDLE && tap_reset_i) reset_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (tap_reset_i) begin
                        state  <= ST_RESET_SEQ;
                        lead   <= 1'b1;
                        busy_o <= 1'b1;
                    end else if (start_i) begin
                        state      <= ST_HEADER;
                        lead       <= 1'b1;
                        busy_o     <= 1'b1;
                        ir_q       <= is_ir_i;
                        shift_len  <= (len_i > 7'd64) ? 7'd64 : len_i;
                        shift_data <= data_i;
                    end
                end

                ST_DONE: begin
                    if (reset_pend || tap_reset_i) begin
                        state      <= ST_RESET_SEQ;
                        lead       <= 1'b1;
                        busy_o     <= 1'b1;
                        reset_pend <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    if (lead) begin
                        // First low clk of a sequence; a zero-length scan ends here
                        lead   <= 1'b0;
                        busy_o <= 1'b1;
                        if (state == ST_HEADER && shift_len == 7'd0) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end else begin
                            tck_idx  <= '0;
                            div_cnt  <= DIV_LOAD;
                            jtag_clk <= 1'b0;
                            jtag_tms <= tms_of(state, 8'd0, ir_q, shift_len);
                            jtag_tdi <= 1'b0;
                        end
                    end else if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else if (!jtag_clk) begin
                        jtag_clk <= 1'b1;
                        div_cnt  <= DIV_LOAD;
                        if (state == ST_SHIFT) capture <= {jtag_tdo, capture[63:1]};
                    end else begin
                        jtag_clk <= 1'b0;
                        div_cnt  <= DIV_LOAD;
                        tck_idx  <= adv_idx;
                        state    <= adv_state;
                        if (state == ST_SHIFT) shift_data <= shift_data >> 1;
                        if (adv_state == ST_DONE) begin
                            done_o   <= 1'b1;
                            busy_o   <= 1'b0;
                            jtag_tdi <= 1'b0;
                            // Received bits sit at the top of capture; align to bit 0
                            if (state == ST_TRAILER)
                                data_o <= capture >> (7'd64 - shift_len);
                        end else begin
                            jtag_tms <= tms_of(adv_state, adv_idx, ir_q, shift_len);
                            jtag_tdi <= adv_tdi;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_host.sv
// Self-checking bench for jtag_host: a TAP-side target model records every TCK
// and drives TDO; expected pin sequences and results come from the scan rules.
module tb_jtag_host;

    localparam int CLK_DIV    = 2;
    localparam int RESET_TCKS = 5;
    localparam int TCK_CLKS   = 2 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        is_ir_i = 1'b0;
    logic [6:0]  len_i = '0;
    logic [63:0] data_i = '0;
    logic        tap_reset_i = 1'b0;
    logic        jtag_tdo = 1'b0;
    logic        busy_o, done_o, jtag_clk, jtag_tms, jtag_tdi;
    logic [63:0] data_o;

    jtag_host #(.CLK_DIV(CLK_DIV), .RESET_TCKS(RESET_TCKS)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .is_ir_i(is_ir_i),
        .len_i(len_i), .data_i(data_i), .tap_reset_i(tap_reset_i),
        .busy_o(busy_o), .done_o(done_o), .data_o(data_o),
        .jtag_clk(jtag_clk), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
        .jtag_tdo(jtag_tdo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Target model: 0 = TDO tied low, 1 = TDI looped back one TCK later, 2 = random
    int   tdo_mode = 0;
    logic tms_q[$];
    logic tdi_q[$];
    logic tdo_q[$];
    int   rise_q[$];
    logic prev_clk = 1'b0, prev_tms = 1'b1, prev_tdi = 1'b0;
    int   hi_run = 0, edge_viol = 0, width_viol = 0;
    logic [63:0] exp_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hi_run   = 0;
            jtag_tdo = 1'b0;
        end else begin
            if (jtag_clk && (jtag_tms !== prev_tms || jtag_tdi !== prev_tdi)) edge_viol++;
            if (jtag_clk && !prev_clk) begin
                tms_q.push_back(jtag_tms);
                tdi_q.push_back(jtag_tdi);
                tdo_q.push_back(jtag_tdo);
                rise_q.push_back(cyc);
                case (tdo_mode)
                    1:       jtag_tdo = jtag_tdi;
                    2:       jtag_tdo = 1'($urandom_range(0, 1));
                    default: jtag_tdo = 1'b0;
                endcase
            end else if (!busy_o) begin
                jtag_tdo = 1'b0;
            end
            if (jtag_clk) hi_run++;
            else if (prev_clk) begin
                if (hi_run != CLK_DIV) width_viol++;
                hi_run = 0;
            end
        end
        prev_clk = jtag_clk;
        prev_tms = jtag_tms;
        prev_tdi = jtag_tdi;
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        tms_q.delete();
        tdi_q.delete();
        tdo_q.delete();
        rise_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (!busy_o && !done_o) seen = 1'b1;
        end
        if (!seen) check_val("idle_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget && dcyc < 0; i++) begin
            @(negedge clk);
            if (done_o) dcyc = cyc;
        end
        check_val("done_seen", (dcyc >= 0), 1);
    endtask

    task automatic grab(input int from, output int n, output logic [127:0] tms_v,
                        output logic [127:0] tdi_v, output int gaps);
        n = tms_q.size() - from;
        tms_v = '0;
        tdi_v = '0;
        gaps = 0;
        for (int j = 0; j < n && j < 128; j++) begin
            tms_v[j] = tms_q[from + j];
            tdi_v[j] = tdi_q[from + j];
            if (j > 0 && rise_q[from + j] - rise_q[from + j - 1] != TCK_CLKS) gaps++;
        end
    endtask

    task automatic check_reset_seq(input int from);
        int n, g;
        logic [127:0] tv, dv;
        grab(from, n, tv, dv, g);
        check_val("rst_tck_count", n, RESET_TCKS + 1);
        check_val("rst_tms", tv, (128'd1 << RESET_TCKS) - 128'd1);
        check_val("rst_tdi", dv, 0);
        check_val("rst_period", g, 0);
    endtask

    task automatic run_scan(input bit ir, input int len, input logic [63:0] d,
                            input int mode, input bit inject);
        int lc, h, n_exp, acc, dcyc, dcyc2, n_got, gaps, n_scan;
        logic [127:0] tms_e, tdi_e, tms_g, tdi_g;
        logic [63:0] mask;
        wait_idle(500);
        clear_log();
        tdo_mode = mode;
        start_i = 1'b1;
        is_ir_i = ir;
        len_i   = 7'(len);
        data_i  = d;
        acc     = cyc + 1;
        @(negedge clk);
        start_i = 1'b0;
        data_i  = {$urandom, $urandom};
        len_i   = 7'($urandom);
        is_ir_i = 1'($urandom);
        if (inject) begin
            repeat (6) @(negedge clk);
            start_i     = 1'b1;
            is_ir_i     = 1'b1;
            len_i       = 7'd3;
            tap_reset_i = 1'b1;
            @(negedge clk);
            start_i     = 1'b0;
            tap_reset_i = 1'b0;
        end
        wait_done(1000, dcyc);

        lc = (len > 64) ? 64 : len;
        h  = ir ? 4 : 3;
        n_exp = 0;
        tms_e = '0;
        tdi_e = '0;
        if (lc > 0) begin
            tms_e[0] = 1'b1;
            n_exp = 1;
            if (ir) begin
                tms_e[1] = 1'b1;
                n_exp = 2;
            end
            n_exp += 2;
            for (int k = 0; k < lc; k++) begin
                tdi_e[n_exp] = d[k];
                tms_e[n_exp] = (k == lc - 1);
                n_exp++;
            end
            tms_e[n_exp] = 1'b1;
            n_exp += 2;
            mask = (lc == 64) ? '1 : ((64'd1 << lc) - 64'd1);
            case (mode)
                1: exp_data = (d << 1) & mask;
                2: begin
                    exp_data = '0;
                    for (int k = 0; k < lc; k++)
                        if (h + k < tdo_q.size()) exp_data[k] = tdo_q[h + k];
                end
                default: exp_data = '0;
            endcase
        end

        grab(0, n_got, tms_g, tdi_g, gaps);
        n_scan = n_got;
        check_val("tck_count", n_got, n_exp);
        check_val("tms_seq", tms_g, tms_e);
        check_val("tdi_seq", tdi_g, tdi_e);
        check_val("tck_period", gaps, 0);
        check_val("latency", dcyc - acc, (lc == 0) ? 1 : (h + lc + 2) * TCK_CLKS + 1);
        check_val("data_o", data_o, exp_data);
        check_val("busy_at_done", busy_o, 0);

        if (inject) begin
            wait_done(500, dcyc2);
            check_reset_seq(n_scan);
            check_val("data_after_rst", data_o, exp_data);
            repeat (40) @(negedge clk);
            check_val("late_start_busy", busy_o, 0);
            check_val("late_start_tcks", tms_q.size(), n_scan + RESET_TCKS + 1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dcyc, ln;
        bit reached;

        // Reset values and the automatic reset sequence on release
        repeat (3) @(negedge clk);
        check_val("rst_pins", {jtag_clk, jtag_tms, jtag_tdi, busy_o, done_o}, 5'b01000);
        check_val("rst_data", data_o, 0);
        clear_log();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("busy_after_rst", busy_o, 1);
        wait_done(500, dcyc);
        check_reset_seq(0);
        check_val("rst_done_busy", busy_o, 0);
        @(negedge clk);
        check_val("busy_after_rst_done", busy_o, 0);

        run_scan(1'b1, 5, 64'h11, 0, 1'b0);
        run_scan(1'b0, 41, 64'h1_2345_6789A, 1, 1'b0);

        // Reset asserted mid-SHIFT
        wait_idle(500);
        clear_log();
        tdo_mode = 2;
        start_i = 1'b1;
        is_ir_i = 1'b0;
        len_i   = 7'd30;
        data_i  = {$urandom, $urandom};
        @(negedge clk);
        start_i = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            @(negedge clk);
            if (tms_q.size() >= 8 && jtag_clk) reached = 1'b1;
        end
        check_val("reached_shift", reached, 1);
        #1 rst_n = 1'b0;
        #1;
        check_val("abort_pins", {jtag_clk, jtag_tms, jtag_tdi}, 3'b010);
        check_val("abort_flags", {busy_o, done_o}, 2'b00);
        check_val("abort_data", data_o, 0);
        exp_data = '0;
        @(negedge clk);
        clear_log();
        rst_n = 1'b1;
        wait_done(500, dcyc);
        check_reset_seq(0);

        // Length boundaries
        run_scan(1'b0, 0, 64'hDEAD_BEEF_0000_0001, 2, 1'b0);
        run_scan(1'b1, 0, 64'h1234, 1, 1'b0);
        run_scan(1'b0, 100, {$urandom, $urandom}, 2, 1'b0);
        run_scan(1'b1, 64, {$urandom, $urandom}, 1, 1'b0);
        run_scan(1'b0, 1, 64'h1, 2, 1'b0);

        // start_i and tap_reset_i pulsed while busy
        run_scan(1'b0, 8, {$urandom, $urandom}, 2, 1'b1);

        for (int t = 0; t < 14; t++) begin
            case ($urandom_range(0, 5))
                0:       ln = 0;
                1:       ln = 64 + $urandom_range(0, 63);
                2:       ln = 1;
                default: ln = $urandom_range(1, 64);
            endcase
            run_scan(1'($urandom_range(0, 1)), ln, {$urandom, $urandom},
                     $urandom_range(0, 2), 1'b0);
        end

        check_val("tms_tdi_edge_rule", edge_viol, 0);
        check_val("tck_high_width", width_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
